ps2_letter_decoder: RTL and testbench
=====================================

// Module: ps2_letter_decoder
// PURPOSE
//  Upstream stage of the hangman datapath: receives PS/2 keyboard frames and decodes
//  set-2 scan codes into 5-bit letter codes (A=1..Z=26) for the datapath char/guess inputs.
//  Emits one single-cycle strobe per key press; ignores releases and typematic repeats.
//  Separately strobes Enter, which the control FSM uses to end word entry.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  clk cycles with no PS/2 falling edge before a partial frame is aborted
//  SYNC_STAGES     2      flip-flop depth of the ps2_clk/ps2_dat synchronisers (min 2)
// PORTS
//  clk          in   1  system clock (50 MHz)
//  resetn       in   1  asynchronous, active-high reset
//  ps2_clk      in   1  raw PS/2 clock from keyboard (asynchronous)
//  ps2_dat      in   1  raw PS/2 data from keyboard (asynchronous)
//  letter       out  5  last decoded letter, 1..26; 0 = none since reset
//  letter_valid out  1  1-cycle strobe, letter updated this cycle
//  enter_pulse  out  1  1-cycle strobe on Enter make (code 5A)
//  frame_err    out  1  1-cycle strobe on parity, start, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, break/ext/held flags clear, shift reg 0, timer 0.
//  Input: ps2_clk, ps2_dat pass through SYNC_STAGES FFs; a falling edge = synced clk 1->0 in consecutive cycles.
//  Bits are sampled from synced ps2_dat only on falling edges.
//  Frame FSM, one transition per falling edge:
//   IDLE:   bit 0 -> DATA with bit count 0; bit 1 -> stay IDLE and pulse frame_err.
//   DATA:   shift right, LSB first; after 8 bits -> PARITY.
//   PARITY: store bit -> STOP.
//   STOP:   stop bit must be 1 and XOR(data,parity) must be 1 (odd parity).
//           If both hold, raise byte_rdy; otherwise pulse frame_err and clear break/ext.
//           Either way -> IDLE.
//  Timeout: counter clears on every falling edge and counts only while not IDLE.
//   On reaching TIMEOUT_CYCLES-1: -> IDLE, frame_err pulse, byte dropped.
//  Code layer, processing byte_rdy:
//   F0 sets break; E0 sets ext.
//   Any other byte with break or ext set is consumed silently and clears both flags.
//   On a break of the held key, held clears.
//   Plain letter code, with held != code: letter <= index, letter_valid=1, held <= code.
//   Plain letter code, with held == code: typematic repeat, no strobe.
//   5A: enter_pulse=1 (repeats of 5A suppressed the same way).
//   Any other plain code: ignored.
//  Letter table (A..Z, hex): 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
//  Latency: strobes assert exactly 1 clk after the cycle detecting the stop-bit falling edge.
//   The decode is a registered table lookup.
//  letter holds its value between strobes. letter_valid and enter_pulse never assert together.
//  Error or timeout never disturbs letter or the held key.
//  Reset mid-frame: immediate return to reset state; any in-flight byte is lost.
// TESTING
//  1. Frame 1C, odd parity 0 -> letter=1, letter_valid high exactly 1 cycle; letter stays 1.
//  2. 1C,1C,1C (typematic) -> single strobe. Then F0,1C,1C -> second strobe, letter=1.
//  3. 1A (Z) with parity bit flipped -> frame_err 1 cycle, no letter_valid, letter unchanged.
//  4. Send 5 bits, then stall TIMEOUT_CYCLES cycles -> frame_err once.
//     A following full 4D frame -> letter=16 (P).
//  5. E0,1C -> no strobe. 5A -> enter_pulse only. 76 (Esc) -> no output.
//  6. Assert resetn mid-DATA of 2C, then send a clean 2C -> letter=20 (T), one strobe;
//     all outputs 0 while in reset.

Source files
------------

// File: rtl/ps2_letter_decoder.sv
`timescale 1ns/1ps
// ps2_letter_decoder: PS/2 set-2 frame receiver and letter/Enter decoder for the hangman datapath.
// Latency: strobes fire 1 clk after the cycle that sees the stop-bit falling edge (SYNC_STAGES+1 clk after the ps2_clk pin falls).
// Backpressure: none; the keyboard cannot be stalled, so every strobe is a single-cycle pulse.
// Ports:
//   clk, resetn (async, active-high)      - system clock and reset
//   ps2_clk, ps2_dat                      - raw asynchronous keyboard lines
//   letter[4:0]                           - last decoded letter, A=1..Z=26, 0 until the first press
//   letter_valid, enter_pulse, frame_err  - single-cycle strobes
module ps2_letter_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       enter_pulse,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   sclk_d;
    logic                   fall, sdat;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [TW-1:0]          timer;
    logic                   byte_rdy, stop_err, err;
    logic                   brk, ext;
    logic [7:0]             held;
    logic [4:0]             letter_idx;

    // Synchronisers reset to 1 so the idle-high lines cannot look like a falling edge out of reset.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            sclk_d   <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            sclk_d   <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall = sclk_d & ~clk_sync[SYNC_STAGES-1];
    assign sdat = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else        state <= state_nxt;
    end

    // A falling edge always wins over the timeout in the same cycle, since the edge restarts the timer.
    always_comb begin
        state_nxt = state;
        byte_rdy  = 1'b0;
        stop_err  = 1'b0;
        err       = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (sdat) err = 1'b1;
                    else      state_nxt = DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    if (sdat && (^{shreg, par_bit})) byte_rdy = 1'b1;
                    else begin
                        stop_err = 1'b1;
                        err      = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && timer == TMAX) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            timer   <= '0;
        end else begin
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {sdat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_bit <= sdat;
                    default: ;
                endcase
            end
            if (fall || state_nxt == IDLE) timer <= '0;
            else                           timer <= timer + 1'b1;
        end
    end

    function automatic logic [4:0] decode_letter(input logic [7:0] code);
        case (code)
            8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;
            8'h23: return 5'd4;   8'h24: return 5'd5;   8'h2B: return 5'd6;
            8'h34: return 5'd7;   8'h33: return 5'd8;   8'h43: return 5'd9;
            8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
            8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;
            8'h4D: return 5'd16;  8'h15: return 5'd17;  8'h2D: return 5'd18;
            8'h1B: return 5'd19;  8'h2C: return 5'd20;  8'h3C: return 5'd21;
            8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
            8'h35: return 5'd25;  8'h1A: return 5'd26;
            default: return 5'd0;
        endcase
    endfunction

    assign letter_idx = decode_letter(shreg);

    // Code layer: break/extended prefixes swallow the following byte; 'held' remembers the
    // key currently down so typematic repeats of it produce no further strobes.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            letter       <= '0;
            letter_valid <= 1'b0;
            enter_pulse  <= 1'b0;
            frame_err    <= 1'b0;
            brk          <= 1'b0;
            ext          <= 1'b0;
            held         <= '0;
        end else begin
            letter_valid <= 1'b0;
            enter_pulse  <= 1'b0;
            frame_err    <= err;
            if (stop_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (byte_rdy) begin
                if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (brk || ext) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (brk && !ext && shreg == held) held <= '0;
                end else if (letter_idx != 5'd0) begin
                    if (held != shreg) begin
                        letter       <= letter_idx;
                        letter_valid <= 1'b1;
                        held         <= shreg;
                    end
                end else if (shreg == 8'h5A) begin
                    if (held != shreg) begin
                        enter_pulse <= 1'b1;
                        held        <= shreg;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
`timescale 1ns/1ps
module tb_ps2_letter_decoder;

    localparam int TO   = 300;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [4:0] letter;
    logic       letter_valid, enter_pulse, frame_err;

    int vectors = 0, miscompares = 0;
    int cyc = 0, fall_cyc = 0, lv_lat = -1;
    int lv_cnt = 0, ep_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int lv_b, ep_b, fe_b;

    ps2_letter_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .letter(letter), .letter_valid(letter_valid),
        .enter_pulse(enter_pulse), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (letter_valid) begin
            lv_cnt <= lv_cnt + 1;
            lv_lat <= cyc - fall_cyc;
        end
        if (enter_pulse) ep_cnt <= ep_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (letter_valid && enter_pulse) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits bits (start, data LSB first, odd parity, stop) of a frame.
    task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic snap();
        lv_b = lv_cnt;
        ep_b = ep_cnt;
        fe_b = fe_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_letter", int'(letter), 0);
        chk("rst_lv", int'(letter_valid), 0);
        chk("rst_ep", int'(enter_pulse), 0);
        chk("rst_fe", int'(frame_err), 0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);

        // 1: A, latency SYNC_STAGES+1 from the stop-bit fall at the pin
        snap();
        send_byte(8'h1C);
        chk("t1_letter", int'(letter), 1);
        chk("t1_lv_once", lv_cnt - lv_b, 1);
        chk("t1_latency", lv_lat, 3);
        repeat (20) @(negedge clk);
        chk("t1_hold", int'(letter), 1);

        // 2: release, then typematic repeats give one strobe; release+press gives another
        snap();
        send_byte(8'hF0); send_byte(8'h1C);
        chk("t2_release", lv_cnt - lv_b, 0);
        snap();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        chk("t2_typematic", lv_cnt - lv_b, 1);
        snap();
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
        chk("t2_repress", lv_cnt - lv_b, 1);
        chk("t2_letter", int'(letter), 1);

        // 3: Z with bad parity, then clean Z
        snap();
        send_bits(8'h1A, 1'b1, 11);
        chk("t3_fe", fe_cnt - fe_b, 1);
        chk("t3_no_lv", lv_cnt - lv_b, 0);
        chk("t3_letter", int'(letter), 1);
        snap();
        send_byte(8'h1A);
        chk("t3_z", int'(letter), 26);
        chk("t3_z_lv", lv_cnt - lv_b, 1);

        // 4: partial frame then stall past the timeout, then P
        snap();
        send_bits(8'h4D, 1'b0, 5);
        repeat (TO + 20) @(negedge clk);
        chk("t4_timeout_fe", fe_cnt - fe_b, 1);
        chk("t4_letter_kept", int'(letter), 26);
        snap();
        send_byte(8'h4D);
        chk("t4_p", int'(letter), 16);
        chk("t4_p_lv", lv_cnt - lv_b, 1);

        // 5: extended code ignored, Enter strobes, Esc ignored
        snap();
        send_byte(8'hE0); send_byte(8'h1C);
        chk("t5_ext_lv", lv_cnt - lv_b, 0);
        snap();
        send_byte(8'h5A);
        chk("t5_enter", ep_cnt - ep_b, 1);
        chk("t5_enter_no_lv", lv_cnt - lv_b, 0);
        chk("t5_letter", int'(letter), 16);
        snap();
        send_byte(8'h5A);
        chk("t5_enter_rep", ep_cnt - ep_b, 0);
        snap();
        send_byte(8'h76);
        chk("t5_esc_lv", lv_cnt - lv_b, 0);
        chk("t5_esc_ep", ep_cnt - ep_b, 0);
        chk("t5_esc_fe", fe_cnt - fe_b, 0);
        chk("never_both", both_cnt, 0);

        // 6: reset mid-DATA of T, then a clean T
        send_bits(8'h2C, 1'b0, 5);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_letter", int'(letter), 0);
        chk("t6_rst_lv", int'(letter_valid), 0);
        chk("t6_rst_ep", int'(enter_pulse), 0);
        chk("t6_rst_fe", int'(frame_err), 0);
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        send_byte(8'h2C);
        chk("t6_t", int'(letter), 20);
        chk("t6_t_lv", lv_cnt - lv_b, 1);
        chk("t6_no_fe", fe_cnt - fe_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
